b1_if_gen: RTL and testbench

Synthetic B1 IF sample source. It is the transmit-side counterpart of the acquisition/tracking receive chain. It generates 8-bit IF samples: carrier NCO cosine × B1I Gold-code PRN × optional BOC(1,1) subcarrier × navigation data bit. The output is in the same format the receiver consumes on its sample input. Used as an on-chip loopback stimulus for acquisition/tracking bring-up, selected in place of the ADC bus at top level.

---
 rtl/b1_if_gen.sv | 133 +++++++++++++
 tb/tb_b1_if_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/b1_if_gen.sv
// b1_if_gen: synthetic B1 IF sample source (carrier cos x Gold PRN x BOC subcarrier x nav bit)
// Ports:
//   rx_clk, rx_rst (async, active-low)  clock and reset
//   rx_en           run enable; low freezes NCOs, LFSRs and counters
//   rx_cfg_load     1-cycle pulse: latch config and restart from the given phase
//   rx_car_fcw      carrier NCO frequency control word
//   rx_prn_fcw      code NCO FCW; one overflow = one half-chip
//   rx_code_phs     initial chip phase (>= CODE_LEN treated as 0)
//   rx_data_bit     nav bit, sampled when the chip counter wraps
//   tx_src          two's-complement IF sample, tx_src_vld qualifies it
//   tx_epoch        pulses with the first sample at chip 0, half-chip 0
//   tx_chip_cnt     chip index of the current tx_src
module b1_if_gen #(
  parameter int CODE_LEN = 2046,
  parameter int G2_TAP1  = 1,
  parameter int G2_TAP2  = 3,
  parameter int BOC_EN   = 1,
  parameter int AMP      = 100
) (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic        rx_en,
  input  logic        rx_cfg_load,
  input  logic [31:0] rx_car_fcw,
  input  logic [31:0] rx_prn_fcw,
  input  logic [11:0] rx_code_phs,
  input  logic        rx_data_bit,
  output logic [7:0]  tx_src,
  output logic        tx_src_vld,
  output logic        tx_epoch,
  output logic [11:0] tx_chip_cnt
);
  typedef enum logic [1:0] {IDLE, LOAD, SEEK, RUN} state_t;
  localparam logic [11:1] INIT = 11'b01010101010;
  localparam logic BOC = BOC_EN != 0;
  state_t state;
  logic [31:0] car_fcw, prn_fcw, car_acc, prn_acc, prn_sum;
  logic [11:0] seek, chip, chip_nxt, p1_chip;
  logic [11:1] g1, g2, g1_nxt, g2_nxt;
  logic [7:0] p1_lut;
  logic half, data, epoch_pend, p1_vld, p1_sym, p1_epoch, prn, wrap, carry;
  // Quarter-wave cosine in Q16, scaled by AMP and folded by symmetry into 16 entries.
  function automatic logic [7:0] lut(input logic [3:0] k);
    int j, i, q, m;
    j = k[3] ? 16 - int'(k) : int'(k);
    i = j > 4 ? 8 - j : j;
    q = i == 0 ? 65536 : i == 1 ? 60547 : i == 2 ? 46341 : i == 3 ? 25080 : 0;
    m = (AMP * q + 32768) >>> 16;
    return 8'(j > 4 ? -m : m);
  endfunction
  assign prn = g1[11] ^ g2[G2_TAP1] ^ g2[G2_TAP2];
  assign wrap = chip == 12'(CODE_LEN - 1);
  assign chip_nxt = wrap ? 12'd0 : chip + 12'd1;
  assign {carry, prn_sum} = {1'b0, prn_acc} + {1'b0, prn_fcw};
  // Code truncation: both generators restart from INIT when the chip counter wraps.
  assign g1_nxt = wrap ? INIT : {g1[10:1], ^{g1[1], g1[7], g1[8], g1[9], g1[10], g1[11]}};
  assign g2_nxt = wrap ? INIT : {g2[10:1], ^{g2[1], g2[2], g2[3], g2[4], g2[5], g2[8], g2[9], g2[11]}};
  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      state <= IDLE;
      car_fcw <= '0;
      prn_fcw <= '0;
      car_acc <= '0;
      prn_acc <= '0;
      seek <= '0;
      chip <= '0;
      g1 <= INIT;
      g2 <= INIT;
      half <= 1'b0;
      data <= 1'b0;
      epoch_pend <= 1'b0;
      p1_vld <= 1'b0;
      p1_lut <= '0;
      p1_sym <= 1'b0;
      p1_chip <= '0;
      p1_epoch <= 1'b0;
      tx_src <= '0;
      tx_src_vld <= 1'b0;
      tx_epoch <= 1'b0;
      tx_chip_cnt <= '0;
    end else if (rx_cfg_load) begin
      state <= LOAD;
      car_fcw <= rx_car_fcw;
      prn_fcw <= rx_prn_fcw;
      seek <= rx_code_phs >= 12'(CODE_LEN) ? 12'd0 : rx_code_phs;
      p1_vld <= 1'b0;
      tx_src_vld <= 1'b0;
      tx_epoch <= 1'b0;
    end else begin
      // Valid flags flow through the pipe so a stall neither drops nor repeats samples.
      p1_vld <= state == RUN && rx_en;
      tx_src_vld <= p1_vld;
      tx_epoch <= p1_vld & p1_epoch;
      if (p1_vld) begin
        tx_src <= p1_sym ? -p1_lut : p1_lut;
        tx_chip_cnt <= p1_chip;
      end
      if (state == LOAD) begin
        car_acc <= '0;
        prn_acc <= '0;
        chip <= '0;
        half <= 1'b0;
        data <= 1'b0;
        g1 <= INIT;
        g2 <= INIT;
        epoch_pend <= seek == 12'd0;
        state <= seek != 12'd0 ? SEEK : RUN;
      end else if (state == SEEK) begin
        g1 <= g1_nxt;
        g2 <= g2_nxt;
        chip <= chip_nxt;
        seek <= seek - 12'd1;
        state <= seek == 12'd1 ? RUN : SEEK;
      end else if (state == RUN && rx_en) begin
        p1_lut <= lut(car_acc[31:28]);
        p1_sym <= prn ^ (BOC & half) ^ data;
        p1_chip <= chip;
        p1_epoch <= epoch_pend;
        car_acc <= car_acc + car_fcw;
        prn_acc <= prn_sum;
        half <= half ^ carry;
        // Next state is chip 0 / half 0 only when a full chip completes at the last chip.
        epoch_pend <= carry & half & wrap;
        if (carry & half) begin
          g1 <= g1_nxt;
          g2 <= g2_nxt;
          chip <= chip_nxt;
          if (wrap) data <= rx_data_bit;
        end
      end
    end
  end
endmodule

// File: tb/tb_b1_if_gen.sv
// tb_b1_if_gen: scoreboard bench for b1_if_gen against a step-indexed reference model
module tb_b1_if_gen;
  localparam int CL = 2046, T1 = 1, T2 = 3, BOC = 1, AMP = 100;
  logic clk = 0, rst_n = 0, en = 0, cfg = 0, dbit = 0;
  logic [31:0] car = 0, prn = 0;
  logic [11:0] phs = 0;
  logic [7:0] src;
  logic vld, epoch;
  logic [11:0] chipc;
  always #5 clk = ~clk;
  b1_if_gen dut (
    .rx_clk(clk), .rx_rst(rst_n), .rx_en(en), .rx_cfg_load(cfg),
    .rx_car_fcw(car), .rx_prn_fcw(prn), .rx_code_phs(phs), .rx_data_bit(dbit),
    .tx_src(src), .tx_src_vld(vld), .tx_epoch(epoch), .tx_chip_cnt(chipc)
  );
  typedef struct { logic [7:0] src; logic [11:0] chip; logic ep; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  bit code[CL];
  int lut[16];
  int bst = 0, sc = 0, k = 0, mph = 0;
  longint unsigned mcar = 0, mprn = 0;
  bit mdata = 0, gap_chk = 0;
  longint last_ep = -1;
  // Half-chip index since phase 0 of the code, after kk enabled steps.
  function automatic longint unsigned hidx(int kk);
    return longint'(2 * mph) + ((longint'(kk) * mprn) >> 32);
  endfunction
  function automatic exp_t model(int kk);
    exp_t e;
    longint unsigned h;
    int idx;
    bit s;
    h = hidx(kk);
    idx = int'(((longint'(kk) * mcar) >> 28) & 15);
    s = code[int'((h / 2) % CL)] ^ (BOC != 0 && (h % 2) == 1) ^ mdata;
    e.src = s ? 8'(-lut[idx]) : 8'(lut[idx]);
    e.chip = 12'((h / 2) % CL);
    e.ep = (h % (2 * CL)) == 0 && (kk == 0 || hidx(kk - 1) != h);
    return e;
  endfunction
  task automatic chk(input string n, input longint a, input longint x);
    checks++;
    if (a != x) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", n, a, x);
    end
  endtask
  task automatic cyc(input bit e, input bit c);
    en = e;
    cfg = c;
    @(posedge clk);
    #1;
    if (c) begin
      bst = 1;
      q.delete();
      k = 0;
      mcar = car;
      mprn = prn;
      mph = phs >= 12'(CL) ? 0 : int'(phs);
      mdata = 0;
    end else if (bst == 1) begin
      sc = mph;
      bst = mph != 0 ? 2 : 3;
    end else if (bst == 2) begin
      sc--;
      if (sc == 0) bst = 3;
    end else if (bst == 3 && e) begin
      q.push_back(model(k));
      if (hidx(k + 1) / (2 * CL) != hidx(k) / (2 * CL)) mdata = dbit;
      k++;
    end
  endtask
  function automatic int mag(input logic [7:0] v);
    return $signed(v) < 0 ? -int'($signed(v)) : int'($signed(v));
  endfunction
  always @(negedge clk) begin
    exp_t e;
    longint tnow;
    if (rst_n && vld) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sample: unexpected valid sample src=%0d chip=%0d", $signed(src), chipc);
      end else begin
        e = q.pop_front();
        if (src !== e.src || chipc !== e.chip || epoch !== e.ep) begin
          errors++;
          $display("FAIL sample: got src=%0d chip=%0d ep=%0b want src=%0d chip=%0d ep=%0b",
                   $signed(src), chipc, epoch, $signed(e.src), e.chip, e.ep);
        end
      end
      if (epoch) begin
        tnow = $time;
        if (gap_chk && last_ep >= 0) chk("epoch_gap", (tnow - last_ep) / 10, 8184);
        last_ep = tnow;
      end
    end else if (rst_n) begin
      checks++;
      if (epoch) begin
        errors++;
        $display("FAIL epoch_no_vld: got 1 want 0");
      end
    end
  end
  initial begin
    logic [10:0] init_v;
    bit g1[1:11], g2[1:11];
    bit f1, f2;
    int mags[4];
    init_v = 11'b01010101010;
    mags = '{100, 92, 71, 38};
    for (int i = 0; i < 16; i++) lut[i] = $rtoi($floor(AMP * $cos(2.0 * 3.14159265358979 * i / 16.0) + 0.5));
    for (int i = 1; i <= 11; i++) begin
      g1[i] = init_v[i - 1];
      g2[i] = init_v[i - 1];
    end
    for (int c = 0; c < CL; c++) begin
      code[c] = g1[11] ^ g2[T1] ^ g2[T2];
      f1 = g1[1] ^ g1[7] ^ g1[8] ^ g1[9] ^ g1[10] ^ g1[11];
      f2 = g2[1] ^ g2[2] ^ g2[3] ^ g2[4] ^ g2[5] ^ g2[8] ^ g2[9] ^ g2[11];
      for (int i = 11; i > 1; i--) begin
        g1[i] = g1[i - 1];
        g2[i] = g2[i - 1];
      end
      g1[1] = f1;
      g2[1] = f2;
    end
    #22;
    chk("rst_src", src, 0);
    chk("rst_vld", vld, 0);
    chk("rst_epoch", epoch, 0);
    chk("rst_chip", chipc, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    // Basic config: vld latency, LUT magnitudes, epoch spacing, data flip across an epoch.
    car = 32'h1000_0000;
    prn = 32'h8000_0000;
    phs = 0;
    gap_chk = 1;
    cyc(1, 1);
    chk("vld_lat0", vld, 0);
    cyc(1, 0);
    chk("vld_lat1", vld, 0);
    cyc(1, 0);
    chk("vld_lat2", vld, 0);
    cyc(1, 0);
    chk("vld_lat3", vld, 1);
    for (int i = 0; i < 4; i++) begin
      chk("lut_mag", mag(src), mags[i]);
      cyc(1, 0);
    end
    for (int i = 0; i < 8300; i++) begin
      dbit = i >= 4000 && i < 8250;
      cyc(1, 0);
    end
    gap_chk = 0;
    // Random FCWs, late phase, random stalls including a 37-cycle gap.
    car = $urandom;
    prn = $urandom | 32'h0100_0000;
    phs = 12'($urandom_range(1500, 2045));
    cyc(1, 1);
    for (int i = 0; i < 5000; i++) begin
      if (i % 300 == 0) dbit = 1'($urandom_range(0, 1));
      cyc(i >= 3000 && i < 3037 ? 1'b0 : 1'($urandom_range(0, 9) != 0), 0);
    end
    // Phase 5 seek with a still carrier.
    car = 0;
    prn = 32'h8000_0000;
    phs = 5;
    dbit = 0;
    cyc(1, 1);
    chk("seek_vld", vld, 0);
    for (int i = 1; i < 8; i++) begin
      cyc(1, 0);
      chk("seek_vld", vld, 0);
    end
    cyc(1, 0);
    chk("seek_vld_rise", vld, 1);
    for (int i = 0; i < 400; i++) cyc(1, 0);
    // Reload mid-RUN.
    car = $urandom;
    prn = $urandom;
    phs = 0;
    cyc(1, 1);
    chk("reload_vld_drop", vld, 0);
    for (int i = 0; i < 300; i++) cyc(1'($urandom_range(0, 3) != 0), 0);
    // Async reset mid-SEEK, then rx_en must be ignored.
    phs = 300;
    cyc(1, 1);
    for (int i = 0; i < 100; i++) cyc(1, 0);
    #2;
    rst_n = 0;
    #1;
    q.delete();
    bst = 0;
    chk("mid_rst_src", src, 0);
    chk("mid_rst_vld", vld, 0);
    chk("mid_rst_epoch", epoch, 0);
    chk("mid_rst_chip", chipc, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 20; i++) cyc(1, 0);
    chk("idle_ignores_en", vld, 0);
    // Out-of-range phase behaves as phase 0.
    car = $urandom;
    prn = $urandom;
    phs = 3000;
    cyc(1, 1);
    cyc(1, 0);
    cyc(1, 0);
    chk("clamp_vld_lo", vld, 0);
    cyc(1, 0);
    chk("clamp_vld_hi", vld, 1);
    for (int i = 0; i < 600; i++) cyc(1'($urandom_range(0, 4) != 0), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
